// File: rtl/rpll_seq_pkg.sv
// rtl/rpll_seq_pkg.sv - shared types and defaults for the PLL lock sequencer
//
// Purpose: state encoding (fixed 3-bit values, visible on the debug port),
// default parameter values and a small sizing helper.
// No ports.

package rpll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_RESET_CYCLES       = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_TIMEOUT_CYCLES     = 65536;
  localparam int DEF_MAX_RETRIES        = 3;

  localparam logic [7:0] LOST_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop single-bit synchronizer
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears every stage to 0
//   d     - asynchronous input level
//   q     - synchronized output (STAGES cycles of latency)

module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/rpll_lock_sequencer.sv
// rtl/rpll_lock_sequencer.sv - PLL reset/lock sequencer with lock-loss tracking
//
// Purpose: pulses the PLL reset, waits for a stable lock, releases the
// downstream reset, and restarts the sequence when lock is lost or a relock
// is requested. Optional attempt timeout with retry limit and FAULT state is
// built only when RPLL_LOCK_TIMEOUT_EN is defined; otherwise WAIT_LOCK waits
// forever and fault is tied low.
// Ports:
//   clkin         - sole clock (PLL reference)
//   reset         - synchronous active-high reset
//   pll_lock      - PLL lock, asynchronous to clkin
//   relock_req    - single-cycle restart request (honoured in RUN/FAULT)
//   pll_reset     - PLL RESET pin drive, active-high
//   sys_reset     - downstream reset, active-high
//   ready         - high only in RUN
//   fault         - high only in FAULT
//   lock_lost_cnt - saturating count of lock losses seen in RUN
//   state         - current state encoding (debug)

module rpll_lock_sequencer
  import rpll_seq_pkg::*;
#(
  parameter int RESET_CYCLES       = DEF_RESET_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state
);

  // One extra bit over the largest terminal count so no state can wrap it.
  localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_STABLE_CYCLES, TIMEOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  if (RESET_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 2 || MAX_RETRIES < 1)
  begin : g_bad_cfg
    $error("rpll_lock_sequencer: parameter below its minimum");
  end

  state_t           cur_st;
  state_t           nxt_st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       lost_nxt;
  logic             lock_s;

`ifdef RPLL_LOCK_TIMEOUT_EN
  localparam int               RTY_W    = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  logic [RTY_W-1:0] retry;
  logic [RTY_W-1:0] retry_nxt;
`endif

  cdc_sync_bit #(
    .STAGES (2)
  ) u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    nxt_st   = cur_st;
    cnt_nxt  = cnt;
    lost_nxt = lock_lost_cnt;
`ifdef RPLL_LOCK_TIMEOUT_EN
    retry_nxt = retry;
`endif

    case (cur_st)
      ST_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          nxt_st  = ST_WAIT_LOCK;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          nxt_st  = ST_STABLE;
          cnt_nxt = '0;
        end
`ifdef RPLL_LOCK_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          cnt_nxt   = '0;
          retry_nxt = retry + 1'b1;
          nxt_st    = (retry_nxt >= RTY_MAX) ? ST_FAULT : ST_RESET_PLL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end

      ST_STABLE: begin
        // A single low lock_s sample discards the run; retries are untouched.
        if (!lock_s) begin
          nxt_st  = ST_WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == STB_LAST) begin
          nxt_st  = ST_RUN;
          cnt_nxt = '0;
`ifdef RPLL_LOCK_TIMEOUT_EN
          retry_nxt = '0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_RUN: begin
        // Lock loss is counted even when a relock request lands on the same cycle.
        if (!lock_s) begin
          lost_nxt = (lock_lost_cnt == LOST_MAX) ? LOST_MAX : lock_lost_cnt + 8'd1;
        end
        if (!lock_s || relock_req) begin
          nxt_st  = ST_RESET_PLL;
          cnt_nxt = '0;
`ifdef RPLL_LOCK_TIMEOUT_EN
          retry_nxt = '0;
`endif
        end
      end

      ST_FAULT: begin
        if (relock_req) begin
          nxt_st  = ST_RESET_PLL;
          cnt_nxt = '0;
`ifdef RPLL_LOCK_TIMEOUT_EN
          retry_nxt = '0;
`endif
        end
      end

      default: begin
        nxt_st  = ST_RESET_PLL;
        cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cur_st        <= ST_RESET_PLL;
      cnt           <= '0;
      lock_lost_cnt <= '0;
      pll_reset     <= 1'b1;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
    end else begin
      cur_st        <= nxt_st;
      cnt           <= cnt_nxt;
      lock_lost_cnt <= lost_nxt;
      pll_reset     <= (nxt_st == ST_RESET_PLL) || (nxt_st == ST_FAULT);
      sys_reset     <= (nxt_st != ST_RUN);
      ready         <= (nxt_st == ST_RUN);
    end
  end

`ifdef RPLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clkin) begin
    if (reset) begin
      retry <= '0;
      fault <= 1'b0;
    end else begin
      retry <= retry_nxt;
      fault <= (nxt_st == ST_FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign state = cur_st;

endmodule

// File: tb/tb_rpll_lock_sequencer.sv
// tb/tb_rpll_lock_sequencer.sv - directed self-checking bench for rpll_lock_sequencer

module tb_rpll_lock_sequencer;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic       clkin      = 1'b0;
  logic       reset      = 1'b1;
  logic       pll_lock   = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int n;
  int exp_lost;

  always #20 clkin = ~clkin;

  rpll_lock_sequencer #(
    .RESET_CYCLES       (4),
    .LOCK_STABLE_CYCLES (8),
    .TIMEOUT_CYCLES     (32),
    .MAX_RETRIES        (2)
  ) u_dut (
    .clkin         (clkin),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req),
    .pll_reset     (pll_reset),
    .sys_reset     (sys_reset),
    .ready         (ready),
    .fault         (fault),
    .lock_lost_cnt (lock_lost_cnt),
    .state         (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clkin);
  endtask

  // Counts falling edges until state matches; -1 if the budget runs out.
  task automatic wait_state(input logic [2:0] s, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clkin);
      cnt++;
    end while (state !== s && cnt < limit);
    if (state !== s) cnt = -1;
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    cyc(1);
    relock_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     state,         S_RESET);
    check({tag, "_pll_reset"}, pll_reset,     1);
    check({tag, "_sys_reset"}, sys_reset,     1);
    check({tag, "_ready"},     ready,         0);
    check({tag, "_fault"},     fault,         0);
    check({tag, "_lost"},      lock_lost_cnt, 0);
  endtask

  initial begin
    // Reset state
    cyc(3);
    check_reset_values("por");

    // Basic lock-up: 4 reset cycles, lock raised 10 cycles after release
    reset = 1'b0;
    wait_state(S_WAIT, 20, n);
    check("rst_len", n, 4);
    check("wait_pll_reset", pll_reset, 0);
    check("wait_sys_reset", sys_reset, 1);
    cyc(6);
    pll_lock = 1'b1;
    wait_state(S_STABLE, 20, n);
    check("sync_latency", n, 3);
    wait_state(S_RUN, 20, n);
    check("stable_len", n, 8);
    check("run_ready", ready, 1);
    check("run_sys_reset", sys_reset, 0);
    check("run_pll_reset", pll_reset, 0);
    check("run_fault", fault, 0);

    // Relock, then a one-cycle lock glitch at stable count 5
    pulse_relock();
    check("relock_state", state, S_RESET);
    check("relock_pll_reset", pll_reset, 1);
    wait_state(S_STABLE, 40, n);
    check("relock_to_stable", n, 5);
    cyc(3);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    wait_state(S_WAIT, 10, n);
    check("glitch_to_wait", n, 2);
    wait_state(S_STABLE, 10, n);
    check("glitch_restable", n, 1);
    wait_state(S_RUN, 20, n);
    check("glitch_full_recount", n, 8);
    check("glitch_lost", lock_lost_cnt, 0);

    // Relock request and lock loss land in the same RUN cycle
    pll_lock = 1'b0;
    cyc(2);
    relock_req = 1'b1;
    cyc(1);
    relock_req = 1'b0;
    check("both_state", state, S_RESET);
    check("both_lost", lock_lost_cnt, 1);
    check("both_sys_reset", sys_reset, 1);
    check("both_ready", ready, 0);
    pll_lock = 1'b1;
    wait_state(S_RUN, 40, n);
    check("both_rerun", n, 13);

    // Repeated lock losses: count saturates at 255
    exp_lost = 1;
    for (int i = 0; i < 255; i++) begin
      pll_lock = 1'b0;
      wait_state(S_RESET, 10, n);
      check("loss_latency", n, 3);
      exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
      check("loss_cnt", lock_lost_cnt, exp_lost);
      check("loss_sys_reset", sys_reset, 1);
      pll_lock = 1'b1;
      wait_state(S_RUN, 40, n);
      check("loss_rerun", n, 13);
    end
    check("lost_saturated", lock_lost_cnt, 255);

    // Reset asserted mid-STABLE
    pulse_relock();
    wait_state(S_STABLE, 20, n);
    check("pre_reset_stable", n, 5);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    check_reset_values("mid");
    cyc(2);
    check_reset_values("hold");
    pll_lock = 1'b0;
    reset = 1'b0;

`ifdef RPLL_LOCK_TIMEOUT_EN
    // No lock ever: two timed-out attempts, then FAULT
    wait_state(S_WAIT, 10, n);
    check("to_rst1", n, 4);
    wait_state(S_RESET, 40, n);
    check("to_wait1", n, 32);
    check("to_retry_fault", fault, 0);
    check("to_retry_pll_reset", pll_reset, 1);
    wait_state(S_WAIT, 10, n);
    check("to_rst2", n, 4);
    wait_state(S_FAULT, 40, n);
    check("to_wait2", n, 32);
    check("fault_fault", fault, 1);
    check("fault_pll_reset", pll_reset, 1);
    check("fault_sys_reset", sys_reset, 1);
    check("fault_ready", ready, 0);
    cyc(20);
    check("fault_sticky", state, S_FAULT);
    pulse_relock();
    check("fault_exit_state", state, S_RESET);
    check("fault_exit_fault", fault, 0);
    check("fault_exit_pll_reset", pll_reset, 1);
    wait_state(S_FAULT, 100, n);
    check("retry_cleared", n, 72);
`else
    // No timeout build: WAIT_LOCK waits forever
    cyc(1000);
    check("nolock_state", state, S_WAIT);
    check("nolock_fault", fault, 0);
    check("nolock_pll_reset", pll_reset, 0);
    check("nolock_sys_reset", sys_reset, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
